// File: rtl/conv2d_pkg.sv
// Shared types and helpers for the conv2d_memwb convolution engine.
// FSM state, output-size, flat-address and saturation functions.
package conv2d_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIAS,
    S_MAC,
    S_WRITE,
    S_DONE
  } state_t;

  function automatic int out_dim(
    input int n,
    input int k,
    input int s,
    input int p
  );
    return (n + 2 * p - k) / s + 1;
  endfunction

  // Row-major flat index of [a][b][c][d] with inner sizes nb, nc, nd.
  function automatic int idx4(
    input int a,
    input int b,
    input int c,
    input int d,
    input int nb,
    input int nc,
    input int nd
  );
    return ((a * nb + b) * nc + c) * nd + d;
  endfunction

  function automatic logic signed [127:0] saturate(
    input logic signed [127:0] a,
    input int                  dw
  );
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    logic signed [127:0] r;
    hi = (128'sd1 <<< (dw - 1)) - 128'sd1;
    lo = -hi - 128'sd1;
    r  = a;
    if (a > hi) begin
      r = hi;
    end else if (a < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv2d_memwb_if.sv
// Job control and memory-port bundle of conv2d_memwb.
// master = engine side, slave = memories / controller side.
interface conv2d_memwb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic                  start;
  logic                  done;
  logic                  valid;
  logic [ADDR_WIDTH-1:0] input_addr;
  logic                  input_en;
  logic [DATA_WIDTH-1:0] input_data;
  logic [ADDR_WIDTH-1:0] weight_addr;
  logic                  weight_en;
  logic [DATA_WIDTH-1:0] weight_data;
  logic [ADDR_WIDTH-1:0] bias_addr;
  logic                  bias_en;
  logic [DATA_WIDTH-1:0] bias_data;
  logic [ADDR_WIDTH-1:0] output_addr;
  logic [DATA_WIDTH-1:0] output_data;
  logic                  output_we;
  logic                  output_en;

  modport master (
    input  start,
    input  input_data,
    input  weight_data,
    input  bias_data,
    output done,
    output valid,
    output input_addr,
    output input_en,
    output weight_addr,
    output weight_en,
    output bias_addr,
    output bias_en,
    output output_addr,
    output output_data,
    output output_we,
    output output_en
  );

  modport slave (
    output start,
    output input_data,
    output weight_data,
    output bias_data,
    input  done,
    input  valid,
    input  input_addr,
    input  input_en,
    input  weight_addr,
    input  weight_en,
    input  bias_addr,
    input  bias_en,
    input  output_addr,
    input  output_data,
    input  output_we,
    input  output_en
  );
endinterface

// File: rtl/conv2d_addr_gen.sv
// Loop counters and memory address/enable generation for conv2d_memwb.
// Taps iterate ic,ky,kx; outputs iterate b,oc,oh,ow (innermost last).
module conv2d_addr_gen
  import conv2d_pkg::*;
#(
  parameter int BATCH_SIZE   = 1,
  parameter int IN_CHANNELS  = 2,
  parameter int OUT_CHANNELS = 1,
  parameter int IN_HEIGHT    = 4,
  parameter int IN_WIDTH     = 4,
  parameter int KERNEL_SIZE  = 2,
  parameter int STRIDE       = 2,
  parameter int PADDING      = 0,
  parameter int ADDR_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clr,
  input  logic                  i_tap_adv,
  input  logic                  i_out_adv,
  input  logic                  i_bias_ph,
  input  logic                  i_mac_ph,
  input  logic                  i_wr_ph,
  output logic [ADDR_WIDTH-1:0] o_in_addr,
  output logic                  o_in_en,
  output logic [ADDR_WIDTH-1:0] o_w_addr,
  output logic                  o_w_en,
  output logic [ADDR_WIDTH-1:0] o_b_addr,
  output logic                  o_b_en,
  output logic [ADDR_WIDTH-1:0] o_o_addr,
  output logic                  o_o_en,
  output logic                  o_last_tap,
  output logic                  o_last_out
);
  localparam int OH = out_dim(IN_HEIGHT, KERNEL_SIZE,
                              STRIDE, PADDING);
  localparam int OW = out_dim(IN_WIDTH, KERNEL_SIZE,
                              STRIDE, PADDING);
  localparam int CW = 16;

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t ONE  = cnt_t'(1);
  localparam cnt_t B_M  = cnt_t'(BATCH_SIZE - 1);
  localparam cnt_t OC_M = cnt_t'(OUT_CHANNELS - 1);
  localparam cnt_t IC_M = cnt_t'(IN_CHANNELS - 1);
  localparam cnt_t K_M  = cnt_t'(KERNEL_SIZE - 1);
  localparam cnt_t OH_M = cnt_t'(OH - 1);
  localparam cnt_t OW_M = cnt_t'(OW - 1);

  cnt_t r_b;
  cnt_t r_oc;
  cnt_t r_oh;
  cnt_t r_ow;
  cnt_t r_ic;
  cnt_t r_ky;
  cnt_t r_kx;

  logic w_kx_l, w_ky_l, w_ic_l;
  logic w_ow_l, w_oh_l, w_oc_l, w_b_l;
  logic w_inb;
  int   w_iy;
  int   w_ix;

  assign w_kx_l = (r_kx == K_M);
  assign w_ky_l = (r_ky == K_M);
  assign w_ic_l = (r_ic == IC_M);
  assign w_ow_l = (r_ow == OW_M);
  assign w_oh_l = (r_oh == OH_M);
  assign w_oc_l = (r_oc == OC_M);
  assign w_b_l  = (r_b == B_M);

  assign o_last_tap = w_kx_l && w_ky_l && w_ic_l;
  assign o_last_out = w_ow_l && w_oh_l && w_oc_l && w_b_l;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kx <= '0;
      r_ky <= '0;
      r_ic <= '0;
    end else if (i_clr || (i_tap_adv && o_last_tap)) begin
      r_kx <= '0;
      r_ky <= '0;
      r_ic <= '0;
    end else if (i_tap_adv) begin
      r_kx <= w_kx_l ? '0 : r_kx + ONE;
      if (w_kx_l) begin
        r_ky <= w_ky_l ? '0 : r_ky + ONE;
        if (w_ky_l) begin
          r_ic <= r_ic + ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ow <= '0;
      r_oh <= '0;
      r_oc <= '0;
      r_b  <= '0;
    end else if (i_clr || (i_out_adv && o_last_out)) begin
      r_ow <= '0;
      r_oh <= '0;
      r_oc <= '0;
      r_b  <= '0;
    end else if (i_out_adv) begin
      r_ow <= w_ow_l ? '0 : r_ow + ONE;
      if (w_ow_l) begin
        r_oh <= w_oh_l ? '0 : r_oh + ONE;
        if (w_oh_l) begin
          r_oc <= w_oc_l ? '0 : r_oc + ONE;
          if (w_oc_l) begin
            r_b <= r_b + ONE;
          end
        end
      end
    end
  end

  // Signed padded coordinates; outside the image means a zero tap.
  assign w_iy = int'(r_oh) * STRIDE + int'(r_ky) - PADDING;
  assign w_ix = int'(r_ow) * STRIDE + int'(r_kx) - PADDING;
  assign w_inb = (w_iy >= 0) && (w_iy < IN_HEIGHT) &&
                 (w_ix >= 0) && (w_ix < IN_WIDTH);

  assign o_in_en = i_mac_ph && w_inb;
  assign o_in_addr = o_in_en ?
    ADDR_WIDTH'(idx4(int'(r_b), int'(r_ic), w_iy, w_ix,
                     IN_CHANNELS, IN_HEIGHT, IN_WIDTH)) : '0;

  assign o_w_en = i_mac_ph;
  assign o_w_addr = o_w_en ?
    ADDR_WIDTH'(idx4(int'(r_oc), int'(r_ic), int'(r_ky),
                     int'(r_kx), IN_CHANNELS, KERNEL_SIZE,
                     KERNEL_SIZE)) : '0;

  assign o_b_en = i_bias_ph;
  assign o_b_addr = o_b_en ? ADDR_WIDTH'(r_oc) : '0;

  assign o_o_en = i_wr_ph;
  assign o_o_addr = o_o_en ?
    ADDR_WIDTH'(idx4(int'(r_b), int'(r_oc), int'(r_oh),
                     int'(r_ow), OUT_CHANNELS, OH, OW)) : '0;

endmodule

// File: rtl/conv2d_memwb.sv
// Sequential 2D convolution engine: bias, one MAC per tap, saturated write.
// Define CONV2D_MEMWB_RELU_EN to clamp negative results to zero.
module conv2d_memwb
  import conv2d_pkg::*;
#(
  parameter int BATCH_SIZE   = 1,
  parameter int IN_CHANNELS  = 2,
  parameter int OUT_CHANNELS = 1,
  parameter int IN_HEIGHT    = 4,
  parameter int IN_WIDTH     = 4,
  parameter int KERNEL_SIZE  = 2,
  parameter int STRIDE       = 2,
  parameter int PADDING      = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ACC_WIDTH    = 64,
  parameter int ADDR_WIDTH   = 16
) (
  input logic            clk,
  input logic            rst_n,
  conv2d_memwb_if.master bus
);
  localparam int PW = 2 * DATA_WIDTH;

  state_t r_state;
  state_t w_next;

  logic w_clr, w_tap_adv, w_out_adv, w_done;
  logic w_bias_ph, w_mac_ph, w_wr_ph;
  logic w_in_en, w_wr_en, w_last_tap, w_last_out;

  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic signed [PW-1:0]         w_a;
  logic signed [PW-1:0]         w_b;
  logic signed [PW-1:0]         w_prod;
  logic signed [DATA_WIDTH-1:0] w_sat;
  logic signed [DATA_WIDTH-1:0] w_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_clr     = 1'b0;
    w_tap_adv = 1'b0;
    w_out_adv = 1'b0;
    w_bias_ph = 1'b0;
    w_mac_ph  = 1'b0;
    w_wr_ph   = 1'b0;
    w_done    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_clr  = 1'b1;
          w_next = S_BIAS;
        end
      end
      S_BIAS: begin
        w_bias_ph = 1'b1;
        w_next    = S_MAC;
      end
      S_MAC: begin
        w_mac_ph  = 1'b1;
        w_tap_adv = 1'b1;
        if (w_last_tap) begin
          w_next = S_WRITE;
        end
      end
      S_WRITE: begin
        w_wr_ph   = 1'b1;
        w_out_adv = 1'b1;
        w_next    = w_last_out ? S_DONE : S_BIAS;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  conv2d_addr_gen #(
    .BATCH_SIZE  (BATCH_SIZE),
    .IN_CHANNELS (IN_CHANNELS),
    .OUT_CHANNELS(OUT_CHANNELS),
    .IN_HEIGHT   (IN_HEIGHT),
    .IN_WIDTH    (IN_WIDTH),
    .KERNEL_SIZE (KERNEL_SIZE),
    .STRIDE      (STRIDE),
    .PADDING     (PADDING),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_clr),
    .i_tap_adv (w_tap_adv),
    .i_out_adv (w_out_adv),
    .i_bias_ph (w_bias_ph),
    .i_mac_ph  (w_mac_ph),
    .i_wr_ph   (w_wr_ph),
    .o_in_addr (bus.input_addr),
    .o_in_en   (w_in_en),
    .o_w_addr  (bus.weight_addr),
    .o_w_en    (bus.weight_en),
    .o_b_addr  (bus.bias_addr),
    .o_b_en    (bus.bias_en),
    .o_o_addr  (bus.output_addr),
    .o_o_en    (w_wr_en),
    .o_last_tap(w_last_tap),
    .o_last_out(w_last_out)
  );

  assign w_a    = PW'($signed(bus.input_data));
  assign w_b    = PW'($signed(bus.weight_data));
  assign w_prod = w_a * w_b;

  // Out-of-bounds taps simply leave the accumulator untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_bias_ph) begin
      r_acc <= ACC_WIDTH'($signed(bus.bias_data));
    end else if (w_mac_ph && w_in_en) begin
      r_acc <= r_acc + ACC_WIDTH'(w_prod);
    end
  end

  assign w_sat = DATA_WIDTH'(saturate(128'(r_acc), DATA_WIDTH));

`ifdef CONV2D_MEMWB_RELU_EN
  assign w_res = w_sat[DATA_WIDTH-1] ? '0 : w_sat;
`else
  assign w_res = w_sat;
`endif

  assign bus.input_en    = w_in_en;
  assign bus.output_en   = w_wr_en;
  assign bus.output_we   = w_wr_en;
  assign bus.valid       = w_wr_en;
  assign bus.output_data = w_wr_en ? w_res : '0;
  assign bus.done        = w_done;

endmodule

// File: tb/tb_conv2d_memwb.sv
// Scoreboard bench for conv2d_memwb over three parameter sets.
// Expected words are queued at job launch and popped on each write.
module tb_conv2d_memwb;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic        oen;
    logic        done;
    logic        ien;
    logic        wen;
    logic        ben;
    logic [15:0] oaddr;
    logic [31:0] odata;
    logic [15:0] iaddr;
    logic [15:0] waddr;
    logic [15:0] baddr;
  } mon_t;

  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic st = 1'b0;
  int   sel = 0;

  logic [31:0] imem [0:63];
  logic [31:0] wmem [0:63];
  logic [31:0] bmem [0:3];

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_ien, n_wen, n_ben;
  int   n_bad = 0;

  mon_t ma, mb, mc, m;

  always #5 clk = ~clk;

  conv2d_memwb_if ifa ();
  conv2d_memwb_if ifb ();
  conv2d_memwb_if ifc ();

  assign ifa.start = st && (sel == 0);
  assign ifb.start = st && (sel == 1);
  assign ifc.start = st && (sel == 2);

  assign ifa.input_data  = imem[ifa.input_addr[5:0]];
  assign ifa.weight_data = wmem[ifa.weight_addr[5:0]];
  assign ifa.bias_data   = bmem[ifa.bias_addr[1:0]];
  assign ifb.input_data  = imem[ifb.input_addr[5:0]];
  assign ifb.weight_data = wmem[ifb.weight_addr[5:0]];
  assign ifb.bias_data   = bmem[ifb.bias_addr[1:0]];
  assign ifc.input_data  = imem[ifc.input_addr[5:0]];
  assign ifc.weight_data = wmem[ifc.weight_addr[5:0]];
  assign ifc.bias_data   = bmem[ifc.bias_addr[1:0]];

  conv2d_memwb u_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifa)
  );

  conv2d_memwb #(
    .OUT_CHANNELS(2)
  ) u_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifb)
  );

  conv2d_memwb #(
    .IN_CHANNELS(1),
    .KERNEL_SIZE(3),
    .STRIDE     (1),
    .PADDING    (1)
  ) u_c (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  assign ma = {ifa.valid, ifa.output_we, ifa.output_en,
               ifa.done, ifa.input_en, ifa.weight_en,
               ifa.bias_en, ifa.output_addr, ifa.output_data,
               ifa.input_addr, ifa.weight_addr, ifa.bias_addr};
  assign mb = {ifb.valid, ifb.output_we, ifb.output_en,
               ifb.done, ifb.input_en, ifb.weight_en,
               ifb.bias_en, ifb.output_addr, ifb.output_data,
               ifb.input_addr, ifb.weight_addr, ifb.bias_addr};
  assign mc = {ifc.valid, ifc.output_we, ifc.output_en,
               ifc.done, ifc.input_en, ifc.weight_en,
               ifc.bias_en, ifc.output_addr, ifc.output_data,
               ifc.input_addr, ifc.weight_addr, ifc.bias_addr};
  assign m = (sel == 1) ? mb : (sel == 2) ? mc : ma;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] relu(input logic [31:0] d);
`ifdef CONV2D_MEMWB_RELU_EN
    return d[31] ? 32'd0 : d;
`else
    return d;
`endif
  endfunction

  task automatic push(input int a, input logic [31:0] d);
    exp_t e;
    e.a = 16'(a);
    e.d = d;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (m.valid) begin
      chk("sb_nonempty", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("wr_addr", 64'(m.oaddr), 64'(e.a));
        chk("wr_data", 64'(m.odata), 64'(e.d));
        chk("wr_strb", 64'({m.we, m.oen}), 64'd3);
      end
    end
    if (m.ien) n_ien++;
    if (m.wen) n_wen++;
    if (m.ben) n_ben++;
    if ((!m.ien && m.iaddr != 0) ||
        (!m.wen && m.waddr != 0) ||
        (!m.ben && m.baddr != 0) ||
        (!m.valid && (m.oaddr != 0 || m.odata != 0 ||
                      m.we || m.oen)))
      n_bad++;
  end

  task automatic run(
    input int s,
    input int exp_cyc,
    input int busy_at
  );
    int cyc;
    sel   = s;
    n_ien = 0;
    n_wen = 0;
    n_ben = 0;
    @(negedge clk);
    st = 1'b1;
    @(posedge clk);
    #1 st = 1'b0;
    cyc = 1;
    while (!m.done && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
      st = (cyc == busy_at);
    end
    chk("done_cyc", 64'(cyc), 64'(exp_cyc));
    st = 1'b1;
    @(posedge clk);
    #1 st = 1'b0;
    chk("done_pulse", 64'(m.done), 64'd0);
    chk("done_start_ign", 64'(m.ben), 64'd0);
    @(negedge clk);
    chk("sb_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic load_base(input logic [31:0] w, input int b0);
    for (int i = 0; i < 64; i++) begin
      imem[i] = 32'(i);
      wmem[i] = w;
    end
    for (int i = 0; i < 4; i++) bmem[i] = 32'd0;
    bmem[0] = 32'(b0);
  endtask

  initial begin
    load_base(32'd1, 0);
    #1;
    chk("rst_all0", 64'(|{ma, mb, mc}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    push(0, 84); push(1, 100); push(2, 148); push(3, 164);
    run(0, 41, 15);
    chk("ien_cnt", 64'(n_ien), 64'd32);
    chk("wen_cnt", 64'(n_wen), 64'd32);
    chk("ben_cnt", 64'(n_ben), 64'd4);

    load_base(32'd2, 10);
    push(0, 178); push(1, 210); push(2, 306); push(3, 338);
    run(0, 41, 0);

    load_base(32'd1, 0);
    for (int i = 8; i < 16; i++) wmem[i] = 32'hFFFF_FFFF;
    push(0, 84); push(1, 100); push(2, 148); push(3, 164);
    push(4, relu(-32'sd84));
    push(5, relu(-32'sd100));
    push(6, relu(-32'sd148));
    push(7, relu(-32'sd164));
    run(1, 81, 30);

    load_base(32'd1, 0);
    for (int i = 0; i < 16; i++) imem[i] = 32'd1;
    for (int oh = 0; oh < 4; oh++)
      for (int ow = 0; ow < 4; ow++)
        push(oh * 4 + ow,
             32'(((oh == 0 || oh == 3) ? 2 : 3) *
                 ((ow == 0 || ow == 3) ? 2 : 3)));
    run(2, 177, 0);
    chk("pad_ien_cnt", 64'(n_ien), 64'd100);
    chk("pad_wen_cnt", 64'(n_wen), 64'd144);
    chk("pad_ben_cnt", 64'(n_ben), 64'd16);

    load_base(32'h7FFF_FFFF, 0);
    for (int i = 0; i < 64; i++) imem[i] = 32'd0;
    imem[0] = 32'h7FFF_FFFF;
    push(0, 32'h7FFF_FFFF); push(1, 0); push(2, 0); push(3, 0);
    run(0, 41, 0);

    imem[0] = 32'h8000_0000;
    push(0, relu(32'h8000_0000));
    push(1, 0); push(2, 0); push(3, 0);
    run(0, 41, 0);

    load_base(32'd1, 0);
    sel = 0;
    @(negedge clk);
    st = 1'b1;
    @(posedge clk);
    #1 st = 1'b0;
    repeat (4) @(posedge clk);
    #2 chk("mid_in_mac", 64'(m.wen), 64'd1);
    rst_n = 1'b0;
    #1 chk("mid_rst_all0", 64'(|ma), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push(0, 84); push(1, 100); push(2, 148); push(3, 164);
    run(0, 41, 20);

    chk("idle_zero", 64'(n_bad), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
